// File: rtl/store_pkg.sv
//------------------------------------------------------------------------------
// Module  : store_pkg
// Brief   : Shared size encodings, byte-enable masks and FSM states for the
//           store narrowing unit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ISSUE2 = 2'd2
  } state_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_mask = BE_BYTE;
      SZ_HALF: size_mask = BE_HALF;
      SZ_WORD: size_mask = BE_WORD;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // One enable bit per byte lane widened to a full-word keep mask.
  function automatic logic [31:0] byte_expand(input logic [3:0] be);
    byte_expand = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_narrow_unit_if.sv
//------------------------------------------------------------------------------
// Module  : store_narrow_unit_if
// Brief   : Request and data-memory handshake bundle for the store unit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface store_narrow_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_size;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;

  logic              done;
  logic              fault;

  // Environment side: execute stage, data memory and control FSM.
  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, fault
  );

  // Store unit side.
  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, fault
  );

endinterface

`default_nettype wire

// File: rtl/store_lane_align.sv
//------------------------------------------------------------------------------
// Module  : store_lane_align
// Brief   : Combinational lane positioning, byte enables and legality check.
//           STORE_SPLIT_UNALIGNED_EN adds the second-beat lanes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  output logic [3:0]  be_lo,
  output logic [31:0] wdata_lo,
`ifdef STORE_SPLIT_UNALIGNED_EN
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_hi,
`endif
  output logic        illegal
);

  logic [3:0]  w_mask;
  logic [31:0] w_data_sized;
  logic [5:0]  w_shamt;

  assign w_mask       = size_mask(size);
  assign w_data_sized = data & byte_expand(w_mask);
  assign w_shamt      = {1'b0, off, 3'b000};

`ifdef STORE_SPLIT_UNALIGNED_EN
  logic [7:0]  w_be_wide;
  logic [63:0] w_data_wide;

  // Lanes pushed past byte 3 spill into the following word.
  assign w_be_wide   = {4'b0000, w_mask} << off;
  assign w_data_wide = {32'd0, w_data_sized} << w_shamt;

  assign be_lo    = w_be_wide[3:0];
  assign wdata_lo = w_data_wide[31:0];
  assign be_hi    = w_be_wide[7:4];
  assign wdata_hi = w_data_wide[63:32];
  assign illegal  = (size == SZ_RSVD);
`else
  logic w_misaligned;

  assign be_lo        = w_mask << off;
  assign wdata_lo     = w_data_sized << w_shamt;
  assign w_misaligned = ((size == SZ_HALF) && off[0]) ||
                        ((size == SZ_WORD) && (off != 2'b00));
  assign illegal      = (size == SZ_RSVD) || w_misaligned;
`endif

endmodule

`default_nettype wire

// File: rtl/store_narrow_unit.sv
//------------------------------------------------------------------------------
// Module  : store_narrow_unit
// Brief   : Narrows a register value to byte/half/word lanes and writes it to
//           data memory over valid/ready. Optional split of unaligned stores
//           into two beats under STORE_SPLIT_UNALIGNED_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_narrow_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  store_narrow_unit_if.slave    bus
);

  state_t              r_state;
  logic                r_req_ready;
  logic                r_mem_valid;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [3:0]          r_mem_be;
  logic                r_done;
  logic                r_fault;

  logic [3:0]          w_be_lo;
  logic [DATA_W-1:0]   w_wdata_lo;
  logic                w_illegal;
  logic [ADDR_W-1:0]   w_word_addr;
  logic                w_accept;

  assign w_word_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
  assign w_accept    = bus.req_valid && r_req_ready && (r_state == IDLE);

`ifdef STORE_SPLIT_UNALIGNED_EN
  logic [3:0]          w_be_hi;
  logic [DATA_W-1:0]   w_wdata_hi;
  logic [3:0]          r_be_hi;
  logic [DATA_W-1:0]   r_wdata_hi;
  logic [ADDR_W-1:0]   c_word_step;

  assign c_word_step = {{(ADDR_W-3){1'b0}}, 3'b100};
`endif

  store_lane_align u_lane_align (
    .off      (bus.req_addr[1:0]),
    .data     (bus.req_data),
    .size     (bus.req_size),
    .be_lo    (w_be_lo),
    .wdata_lo (w_wdata_lo),
`ifdef STORE_SPLIT_UNALIGNED_EN
    .be_hi    (w_be_hi),
    .wdata_hi (w_wdata_hi),
`endif
    .illegal  (w_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'b0000;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
`ifdef STORE_SPLIT_UNALIGNED_EN
      r_be_hi     <= 4'b0000;
      r_wdata_hi  <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_fault <= 1'b1;
            end else begin
              r_state     <= ISSUE;
              r_req_ready <= 1'b0;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_word_addr;
              r_mem_wdata <= w_wdata_lo;
              r_mem_be    <= w_be_lo;
`ifdef STORE_SPLIT_UNALIGNED_EN
              r_be_hi     <= w_be_hi;
              r_wdata_hi  <= w_wdata_hi;
`endif
            end
          end
        end

        ISSUE: begin
          if (bus.mem_ready) begin
`ifdef STORE_SPLIT_UNALIGNED_EN
            if (r_be_hi != 4'b0000) begin
              // Address wraps naturally at the top of the address space.
              r_state     <= ISSUE2;
              r_mem_addr  <= r_mem_addr + c_word_step;
              r_mem_wdata <= r_wdata_hi;
              r_mem_be    <= r_be_hi;
            end else begin
              r_state     <= IDLE;
              r_req_ready <= 1'b1;
              r_mem_valid <= 1'b0;
              r_done      <= 1'b1;
            end
`else
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
`endif
          end
        end

`ifdef STORE_SPLIT_UNALIGNED_EN
        ISSUE2: begin
          if (bus.mem_ready) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif

        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.done      = r_done;
  assign bus.fault     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_store_narrow_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_store_narrow_unit
// Brief   : Self-checking bench for store_narrow_unit (directed + random).
//           Honours STORE_SPLIT_UNALIGNED_EN when defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_store_narrow_unit;

`ifdef STORE_SPLIT_UNALIGNED_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  store_narrow_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  store_narrow_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: place each source byte k at lane off+k across two words.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input int hold, input bit poke);
    logic [63:0] wide;
    logic [7:0]  bem;
    logic [31:0] e_addr [2];
    logic [31:0] e_wd   [2];
    logic [3:0]  e_be   [2];
    int          nb, off, nbeats, lane;
    bit          legal;

    wide = '0;
    bem  = '0;
    off  = int'(a % 4);
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < nb; k++) begin
      lane = off + k;
      wide[lane*8 +: 8] = d[k*8 +: 8];
      bem[lane] = 1'b1;
    end
    legal     = (sz != 2'd3) && (SPLIT || (off % nb) == 0);
    nbeats    = (bem[7:4] != 4'b0000) ? 2 : 1;
    e_addr[0] = a - (a % 4);
    e_addr[1] = e_addr[0] + 32'd4;
    e_wd[0]   = wide[31:0];
    e_wd[1]   = wide[63:32];
    e_be[0]   = bem[3:0];
    e_be[1]   = bem[7:4];

    chk("ready_before_req", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = sz;
    bus.mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.req_valid = poke;
    bus.req_addr  = $urandom;
    bus.req_data  = $urandom;
    bus.req_size  = 2'($urandom_range(0, 2));

    if (!legal) begin
      bus.req_valid = 1'b0;
      chk("fault_pulse", {63'd0, bus.fault}, 64'd1);
      chk("fault_no_valid", {63'd0, bus.mem_valid}, 64'd0);
      chk("fault_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("fault_no_done", {63'd0, bus.done}, 64'd0);
      @(negedge clk);
      chk("fault_clear", {63'd0, bus.fault}, 64'd0);
      chk("fault_still_idle", {63'd0, bus.mem_valid}, 64'd0);
      return;
    end

    for (int b = 0; b < nbeats; b++) begin
      for (int h = 0; h <= hold; h++) begin
        chk("beat_valid", {63'd0, bus.mem_valid}, 64'd1);
        chk("beat_addr", {32'd0, bus.mem_addr}, {32'd0, e_addr[b]});
        chk("beat_be", {60'd0, bus.mem_be}, {60'd0, e_be[b]});
        chk("beat_wdata", {32'd0, bus.mem_wdata}, {32'd0, e_wd[b]});
        chk("busy_not_ready", {63'd0, bus.req_ready}, 64'd0);
        chk("busy_no_pulse", {62'd0, bus.done, bus.fault}, 64'd0);
        bus.mem_ready = (h == hold);
        if (h == hold && b == nbeats - 1) bus.req_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.mem_ready = 1'b0;
    chk("done_pulse", {63'd0, bus.done}, 64'd1);
    chk("done_no_fault", {63'd0, bus.fault}, 64'd0);
    chk("done_valid_low", {63'd0, bus.mem_valid}, 64'd0);
    chk("done_ready", {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);
    chk("done_clear", {63'd0, bus.done}, 64'd0);
    chk("no_extra_write", {63'd0, bus.mem_valid}, 64'd0);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = 2'd0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
    chk("rst_mem_addr", {32'd0, bus.mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, bus.mem_wdata}, 64'd0);
    chk("rst_mem_be", {60'd0, bus.mem_be}, 64'd0);
    chk("rst_pulses", {62'd0, bus.done, bus.fault}, 64'd0);

    do_store(32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 0, 1'b0);
    do_store(32'h0000_0203, 32'h1234_5678, 2'd0, 3, 1'b0);
    do_store(32'h0000_0102, 32'h1234_5678, 2'd1, 1, 1'b0);
    do_store(32'h0000_0101, 32'h1234_5678, 2'd1, 0, 1'b0);
    do_store(32'h0000_0104, 32'h1234_5678, 2'd3, 0, 1'b0);
    do_store(32'h0000_0300, 32'hCAFE_F00D, 2'd2, 2, 1'b1);
    do_store(32'h0000_0302, 32'hCAFE_F00D, 2'd2, 0, 1'b0);
`ifdef STORE_SPLIT_UNALIGNED_EN
    do_store(32'h0000_00FE, 32'hAABB_CCDD, 2'd2, 1, 1'b0);
    do_store(32'hFFFF_FFFF, 32'h0000_BEEF, 2'd1, 0, 1'b0);
`endif

    // Reset in the middle of a held write beat.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0040;
    bus.req_data  = 32'h0BAD_F00D;
    bus.req_size  = 2'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("pre_rst_valid", {63'd0, bus.mem_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, bus.mem_valid}, 64'd0);
    chk("async_rst_ready", {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_no_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    chk("post_rst_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("post_rst_valid", {63'd0, bus.mem_valid}, 64'd0);
    chk("post_rst_done", {63'd0, bus.done}, 64'd0);

    for (int n = 0; n < 40; n++) begin
      do_store($urandom, $urandom, 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
